// File: rtl/chart_judge.sv
// chart_judge: steps a 4-lane arrow chart on sixteenth pulses and judges presses by arrow age.
// Optional feature macro CHART_JUDGE_AUTOPLAY_EN: every armed arrow is judged PERFECT one cycle later.
module chart_judge #(
    parameter int unsigned CHART_LEN     = 64,
    parameter string       CHART_FILE    = "chart.hex",
    parameter int unsigned PERFECT_TICKS = 2,
    parameter int unsigned GOOD_TICKS    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        sixteenth_i,
    input  logic        tick_i,
    input  logic [3:0]  buttons_i,
    output logic [3:0]  arrows_o,
    output logic [3:0]  pending_o,
    output logic [3:0]  judge_valid_o,
    output logic [7:0]  judge_o,
    output logic [15:0] score_o,
    output logic [7:0]  combo_o,
    output logic        done_o
);

    localparam int unsigned     PtrW       = $clog2(CHART_LEN);
    localparam logic [PtrW-1:0] LastPtr    = PtrW'(CHART_LEN - 1);
    localparam logic [2:0]      PerfectAge = 3'(PERFECT_TICKS);
    localparam logic [2:0]      GoodAge    = 3'(GOOD_TICKS);
    localparam logic [1:0]      JNone      = 2'b00;
    localparam logic [1:0]      JPerfect   = 2'b01;
    localparam logic [1:0]      JGood      = 2'b10;
    localparam logic [1:0]      JMiss      = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDrain,
        StDone
    } state_e;

    logic [3:0] chart_rom [CHART_LEN];

    state_e           state_q, state_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0][2:0]  age_q, age_d;
    logic [3:0]       btn_q;
    logic [3:0]       arrows_q, arrows_d;
    logic [3:0]       judge_valid_q, judge_valid_d;
    logic [7:0]       judge_q, judge_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;

    logic        active;
    logic [3:0]  arm;
    logic [3:0]  press;
    logic [1:0]  lane_j;
    logic [3:0]  pts;
    logic [2:0]  hits;
    logic        miss_any;
    logic [16:0] score_sum;
    logic [8:0]  combo_sum;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        pending_d     = pending_q;
        age_d         = age_q;
        arrows_d      = '0;
        judge_valid_d = '0;
        judge_d       = '0;
        score_d       = score_q;
        combo_d       = combo_q;
        lane_j        = JNone;
        pts           = '0;
        hits          = '0;
        miss_any      = 1'b0;
        score_sum     = '0;
        combo_sum     = '0;

        active = (state_q == StPlay) || (state_q == StDrain);
        arm    = ((state_q == StPlay) && sixteenth_i) ? chart_rom[ptr_q] : 4'b0000;
        press  = buttons_i & ~btn_q;

        for (int n = 0; n < 4; n++) begin
            lane_j = JNone;
            if (active && pending_q[n]) begin
`ifdef CHART_JUDGE_AUTOPLAY_EN
                lane_j = JPerfect;
`else
                // Old arrow is resolved before any new arm in the same cycle; a press beats a miss.
                if (press[n]) begin
                    lane_j = (age_q[n] <= PerfectAge) ? JPerfect : JGood;
                end else if ((tick_i && (age_q[n] >= GoodAge)) || arm[n]) begin
                    lane_j = JMiss;
                end else if (tick_i) begin
                    age_d[n] = age_q[n] + 3'd1;
                end
`endif
                if (lane_j != JNone) begin
                    pending_d[n]        = 1'b0;
                    judge_valid_d[n]    = 1'b1;
                    judge_d[2*n +: 2]   = lane_j;
                end
            end
            if (arm[n]) begin
                pending_d[n] = 1'b1;
                age_d[n]     = 3'd0;
                arrows_d[n]  = 1'b1;
            end
        end

        for (int n = 0; n < 4; n++) begin
            unique case (judge_d[2*n +: 2])
                JPerfect: begin
                    pts  = pts + 4'd2;
                    hits = hits + 3'd1;
                end
                JGood: begin
                    pts  = pts + 4'd1;
                    hits = hits + 3'd1;
                end
                JMiss:   miss_any = 1'b1;
                default: ;
            endcase
        end

        score_sum = {1'b0, score_q} + 17'(pts);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        combo_sum = {1'b0, combo_q} + 9'(hits);
        if (miss_any) begin
            combo_d = 8'd0;
        end else begin
            combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end

        unique case (state_q)
            StPlay: begin
                if (sixteenth_i) begin
                    if (ptr_q == LastPtr) begin
                        ptr_d   = '0;
                        state_d = StDrain;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (pending_q == 4'b0000) state_d = StDone;
            end
            StIdle, StDone: ;
            default: ;
        endcase

        // Start from any state restarts the song and discards this cycle's judgements.
        if (start_i) begin
            state_d       = StPlay;
            ptr_d         = '0;
            pending_d     = '0;
            age_d         = '0;
            arrows_d      = '0;
            judge_valid_d = '0;
            judge_d       = '0;
            score_d       = '0;
            combo_d       = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            pending_q     <= '0;
            age_q         <= '0;
            btn_q         <= '0;
            arrows_q      <= '0;
            judge_valid_q <= '0;
            judge_q       <= '0;
            score_q       <= '0;
            combo_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            age_q         <= age_d;
            btn_q         <= buttons_i;
            arrows_q      <= arrows_d;
            judge_valid_q <= judge_valid_d;
            judge_q       <= judge_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
        end
    end

    assign arrows_o      = arrows_q;
    assign pending_o     = pending_q;
    assign judge_valid_o = judge_valid_q;
    assign judge_o       = judge_q;
    assign score_o       = score_q;
    assign combo_o       = combo_q;
    assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_chart_judge.sv
// Directed bench for chart_judge: short 4-entry charts poked into the ROM, hand-computed results.
module tb_chart_judge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        sixteenth_i;
    logic        tick_i;
    logic [3:0]  buttons_i;
    logic [3:0]  arrows_o;
    logic [3:0]  pending_o;
    logic [3:0]  judge_valid_o;
    logic [7:0]  judge_o;
    logic [15:0] score_o;
    logic [7:0]  combo_o;
    logic        done_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    chart_judge #(
        .CHART_LEN    (4),
        .CHART_FILE   (""),
        .PERFECT_TICKS(2),
        .GOOD_TICKS   (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .sixteenth_i  (sixteenth_i),
        .tick_i       (tick_i),
        .buttons_i    (buttons_i),
        .arrows_o     (arrows_o),
        .pending_o    (pending_o),
        .judge_valid_o(judge_valid_o),
        .judge_o      (judge_o),
        .score_o      (score_o),
        .combo_o      (combo_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_chart(input logic [15:0] c);
        dut.chart_rom[0] = c[3:0];
        dut.chart_rom[1] = c[7:4];
        dut.chart_rom[2] = c[11:8];
        dut.chart_rom[3] = c[15:12];
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic pulse_six();
        sixteenth_i = 1'b1;
        step();
        sixteenth_i = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        sixteenth_i = 1'b0;
        tick_i      = 1'b0;
        buttons_i   = 4'h0;
        load_chart(16'hF141);
        step();
        step();
        rst_i = 1'b0;
        step();
        check("reset score", score_o, 16'h0);
        check("reset combo", 16'(combo_o), 16'h0);
        check("reset pending", 16'(pending_o), 16'h0);
        check("reset done", 16'(done_o), 16'h0);
        check("reset jv", 16'(judge_valid_o), 16'h0);

        // Entry 0 = lane 0, one tick, press -> PERFECT.
        pulse_start();
        check("start done", 16'(done_o), 16'h0);
        pulse_six();
        check("arm0 arrows", 16'(arrows_o), 16'h1);
        check("arm0 pending", 16'(pending_o), 16'h1);
        pulse_tick();
        check("arrows one cycle", 16'(arrows_o), 16'h0);
        buttons_i = 4'h1;
        step();
        check("perfect jv", 16'(judge_valid_o), 16'h1);
        check("perfect judge", 16'(judge_o), 16'h01);
        check("perfect score", score_o, 16'd2);
        check("perfect combo", 16'(combo_o), 16'd1);
        check("perfect pending", 16'(pending_o), 16'h0);
        buttons_i = 4'h0;
        step();
        check("judge one cycle", 16'(judge_valid_o), 16'h0);

        // Entry 1 = lane 2, six ticks without a press -> MISS on the sixth.
        pulse_six();
        check("arm2 pending", 16'(pending_o), 16'h4);
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            check("no early miss", 16'(judge_valid_o), 16'h0);
        end
        check("lane2 still pending", 16'(pending_o), 16'h4);
        pulse_tick();
        check("miss jv", 16'(judge_valid_o), 16'h4);
        check("miss judge", 16'(judge_o), 16'h30);
        check("miss combo", 16'(combo_o), 16'd0);
        check("miss pending", 16'(pending_o), 16'h0);
        check("miss score", score_o, 16'd2);

        // Entry 2 = lane 0, four ticks then press -> GOOD; stray press on lane 1 ignored.
        pulse_six();
        for (int i = 0; i < 4; i++) pulse_tick();
        buttons_i = 4'h1;
        step();
        check("good judge", 16'(judge_o), 16'h02);
        check("good score", score_o, 16'd3);
        check("good combo", 16'(combo_o), 16'd1);
        buttons_i = 4'h0;
        step();
        buttons_i = 4'h2;
        step();
        check("stray jv", 16'(judge_valid_o), 16'h0);
        check("stray score", score_o, 16'd3);
        buttons_i = 4'h0;
        step();

        // Entry 3 = all lanes, all pressed at age 0; last entry -> drain -> done.
        pulse_six();
        check("armF pending", 16'(pending_o), 16'hF);
        buttons_i = 4'hF;
        step();
        check("quad jv", 16'(judge_valid_o), 16'hF);
        check("quad judge", 16'(judge_o), 16'h55);
        check("quad score", score_o, 16'd11);
        check("quad combo", 16'(combo_o), 16'd5);
        check("quad not yet done", 16'(done_o), 16'h0);
        buttons_i = 4'h0;
        step();
        check("done after drain", 16'(done_o), 16'h1);
        pulse_tick();
        check("tick ignored in done", 16'(judge_valid_o), 16'h0);

        // Restart; play a 4-entry chart with no presses, all lanes miss together.
        load_chart(16'h8421);
        pulse_start();
        check("restart score", score_o, 16'd0);
        check("restart combo", 16'(combo_o), 16'd0);
        check("restart done", 16'(done_o), 16'h0);
        for (int i = 0; i < 4; i++) pulse_six();
        check("all armed", 16'(pending_o), 16'hF);
        for (int i = 0; i < 5; i++) pulse_tick();
        check("drain no miss yet", 16'(done_o), 16'h0);
        pulse_tick();
        check("drain miss jv", 16'(judge_valid_o), 16'hF);
        check("drain miss judge", 16'(judge_o), 16'hFF);
        check("drain miss pending", 16'(pending_o), 16'h0);
        check("drain not done yet", 16'(done_o), 16'h0);
        step();
        check("done after last miss", 16'(done_o), 16'h1);

        // Re-arm over a pending arrow, then press and re-arm in the same cycle.
        load_chart(16'h0111);
        pulse_start();
        pulse_six();
        pulse_six();
        check("rearm miss jv", 16'(judge_valid_o), 16'h1);
        check("rearm miss judge", 16'(judge_o), 16'h03);
        check("rearm pending", 16'(pending_o), 16'h1);
        check("rearm arrows", 16'(arrows_o), 16'h1);
        buttons_i = 4'h1;
        pulse_six();
        check("press+arm judge", 16'(judge_o), 16'h01);
        check("press+arm score", score_o, 16'd2);
        check("press+arm combo", 16'(combo_o), 16'd1);
        check("press+arm pending", 16'(pending_o), 16'h1);

        // Asynchronous reset mid-song clears outputs without waiting for an edge.
        #3;
        rst_i = 1'b1;
        #1;
        check("async rst score", score_o, 16'd0);
        check("async rst combo", 16'(combo_o), 16'd0);
        check("async rst pending", 16'(pending_o), 16'h0);
        check("async rst arrows", 16'(arrows_o), 16'h0);
        check("async rst jv", 16'(judge_valid_o), 16'h0);
        check("async rst judge", 16'(judge_o), 16'h0);
        step();
        check("rst held jv", 16'(judge_valid_o), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
